// File: rtl/calc_ray_pkg.sv
// Shared defaults, hysteresis state encoding and window-exponent helper for ray_window_stats.
package calc_ray_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_MAX_LOG2   = 8;

  typedef enum logic {
    INSIDE  = 1'b0,
    OUTSIDE = 1'b1
  } hyst_state_e;

  // Limit a requested window exponent to the largest supported one.
  function automatic logic [3:0] clamp_k(input logic [3:0] k, input logic [3:0] k_max);
    return (k > k_max) ? k_max : k;
  endfunction

endpackage

// File: rtl/ray_window_stats_if.sv
// Sample input, configuration and window-statistics output bundle.
interface ray_window_stats_if
  import calc_ray_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAX_LOG2   = DEF_MAX_LOG2
);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] r;
  logic                  clear;
  logic [3:0]            window_log2;
  logic [DATA_WIDTH-1:0] thr_high;
  logic [DATA_WIDTH-1:0] thr_low;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] r_mean;
  logic [DATA_WIDTH-1:0] r_max;
  logic                  out_of_range;
  logic [MAX_LOG2:0]     fill_count;

  modport master (
    output in_valid, r, clear, window_log2, thr_high, thr_low,
    input  out_valid, r_mean, r_max, out_of_range, fill_count
  );

  modport slave (
    input  in_valid, r, clear, window_log2, thr_high, thr_low,
    output out_valid, r_mean, r_max, out_of_range, fill_count
  );

endinterface

// File: rtl/ray_hysteresis.sv
// Two-state hysteresis on completed-window means; equality never transitions.
module ray_hysteresis
  import calc_ray_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  update,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic [DATA_WIDTH-1:0] thr_high,
  input  logic [DATA_WIDTH-1:0] thr_low,
  output logic                  out_of_range
);

  hyst_state_e state_q;

  // State and its registered flag advance only when a window completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= INSIDE;
      out_of_range <= 1'b0;
    end else if (update) begin
      case (state_q)
        INSIDE: begin
          if (value > thr_high) begin
            state_q      <= OUTSIDE;
            out_of_range <= 1'b1;
          end
        end
        OUTSIDE: begin
          if (value < thr_low) begin
            state_q      <= INSIDE;
            out_of_range <= 1'b0;
          end
        end
        default: begin
          state_q      <= INSIDE;
          out_of_range <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ray_window_stats.sv
// Windowed mean/max of ray magnitudes over 2^k samples with hysteresis range flag.
module ray_window_stats
  import calc_ray_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAX_LOG2   = DEF_MAX_LOG2
) (
  input  logic              clk,
  input  logic              reset,
  ray_window_stats_if.slave bus
);

  localparam int unsigned ACC_W = DATA_WIDTH + MAX_LOG2;
  localparam int unsigned CNT_W = MAX_LOG2 + 1;

  logic [ACC_W-1:0]      acc_q;
  logic [DATA_WIDTH-1:0] run_max_q;
  logic [CNT_W-1:0]      fill_q;
  logic [3:0]            k_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] mean_q;
  logic [DATA_WIDTH-1:0] max_q;

  logic [3:0]            k_c;
  logic                  accept_c;
  logic                  complete_c;
  logic [ACC_W-1:0]      sum_c;
  logic [DATA_WIDTH-1:0] max_c;
  logic [DATA_WIDTH-1:0] mean_c;
  logic [CNT_W-1:0]      fill_inc_c;
  logic [CNT_W-1:0]      win_len_c;

  // Window arithmetic; an empty window takes the live exponent, otherwise the latched one.
  always_comb begin
    k_c        = (fill_q == '0) ? clamp_k(bus.window_log2, 4'(MAX_LOG2)) : k_q;
    accept_c   = bus.in_valid & ~bus.clear;
    sum_c      = acc_q + ACC_W'(bus.r);
    max_c      = (bus.r > run_max_q) ? bus.r : run_max_q;
    fill_inc_c = fill_q + CNT_W'(1);
    win_len_c  = CNT_W'(1) << k_c;
    complete_c = accept_c && (fill_inc_c == win_len_c);
    mean_c     = DATA_WIDTH'(sum_c >> k_c);
  end

  // Accumulate samples, publish statistics on completion, restart on clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      run_max_q   <= '0;
      fill_q      <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      mean_q      <= '0;
      max_q       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (bus.clear) begin
        acc_q     <= '0;
        run_max_q <= '0;
        fill_q    <= '0;
      end else if (bus.in_valid) begin
        if (complete_c) begin
          mean_q      <= mean_c;
          max_q       <= max_c;
          out_valid_q <= 1'b1;
          acc_q       <= '0;
          run_max_q   <= '0;
          fill_q      <= '0;
        end else begin
          acc_q     <= sum_c;
          run_max_q <= max_c;
          fill_q    <= fill_inc_c;
          if (fill_q == '0) k_q <= k_c;
        end
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.r_mean     = mean_q;
  assign bus.r_max      = max_q;
  assign bus.fill_count = fill_q;

  ray_hysteresis #(.DATA_WIDTH(DATA_WIDTH)) u_hyst (
    .clk          (clk),
    .reset        (reset),
    .update       (complete_c),
    .value        (mean_c),
    .thr_high     (bus.thr_high),
    .thr_low      (bus.thr_low),
    .out_of_range (bus.out_of_range)
  );

endmodule

// File: tb/tb_ray_window_stats.sv
// Randomized and directed bench for ray_window_stats against a queue-based window model.
module tb_ray_window_stats;

  localparam int unsigned DW = 8;
  localparam int unsigned ML = 8;

  logic clk;
  logic reset;

  ray_window_stats_if #(.DATA_WIDTH(DW), .MAX_LOG2(ML)) bus ();

  ray_window_stats #(.DATA_WIDTH(DW), .MAX_LOG2(ML)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks;
  int unsigned n_fail;

  // Reference model state
  int unsigned win_q[$];
  int unsigned m_k;
  bit          m_valid;
  int unsigned m_mean;
  int unsigned m_max;
  bit          m_oor;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    win_q.delete();
    m_k     = 0;
    m_valid = 0;
    m_mean  = 0;
    m_max   = 0;
    m_oor   = 0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge(input bit v, input int unsigned rv, input bit clr);
    int unsigned sum;
    int unsigned mx;
    m_valid = 0;
    if (clr) begin
      win_q.delete();
    end else if (v) begin
      if (win_q.size() == 0)
        m_k = (int'(bus.window_log2) > int'(ML)) ? ML : int'(bus.window_log2);
      win_q.push_back(rv);
      if (win_q.size() == (1 << m_k)) begin
        sum = 0;
        mx  = 0;
        foreach (win_q[i]) begin
          sum += win_q[i];
          if (win_q[i] > mx) mx = win_q[i];
        end
        m_mean  = sum >> m_k;
        m_max   = mx;
        m_valid = 1;
        if (!m_oor && m_mean > int'(bus.thr_high)) m_oor = 1;
        else if (m_oor && m_mean < int'(bus.thr_low)) m_oor = 0;
        win_q.delete();
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(m_valid));
    check({tag, ".mean"},  32'(bus.r_mean), m_mean);
    check({tag, ".max"},   32'(bus.r_max), m_max);
    check({tag, ".fill"},  32'(bus.fill_count), win_q.size());
    check({tag, ".oor"},   32'(bus.out_of_range), 32'(m_oor));
  endtask

  task automatic step(input string tag, input bit v, input logic [7:0] rv, input bit clr);
    bus.in_valid = v;
    bus.r        = rv;
    bus.clear    = clr;
    @(posedge clk);
    #1;
    model_edge(v, int'(rv), clr);
    compare_all(tag);
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    reset            = 1'b1;
    bus.in_valid     = 1'b0;
    bus.r            = '0;
    bus.clear        = 1'b0;
    bus.window_log2  = 4'd2;
    bus.thr_high     = 8'd200;
    bus.thr_low      = 8'd100;
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    reset = 1'b0;

    // k=2 basic window
    step("w4", 1, 8'd10, 0);
    step("w4", 1, 8'd20, 0);
    step("w4", 1, 8'd30, 0);
    step("w4", 1, 8'd40, 0);
    check("w4.mean_const", 32'(bus.r_mean), 25);
    check("w4.max_const", 32'(bus.r_max), 40);
    check("w4.valid_const", 32'(bus.out_valid), 1);
    step("w4.hold", 0, 8'd0, 0);
    check("w4.hold_mean", 32'(bus.r_mean), 25);

    // k=0 back-to-back completions
    bus.window_log2 = 4'd0;
    step("k0", 1, 8'h7F, 0);
    check("k0.a", 32'(bus.r_mean), 32'h7F);
    step("k0", 1, 8'h01, 0);
    check("k0.b", 32'(bus.r_mean), 32'h01);
    check("k0.b_valid", 32'(bus.out_valid), 1);

    // k=8 full-scale window, accumulator headroom
    bus.window_log2 = 4'd8;
    bus.thr_high    = 8'd255;
    for (int i = 0; i < 256; i++) step("k8", 1, 8'hFF, 0);
    check("k8.mean_const", 32'(bus.r_mean), 32'hFF);
    check("k8.max_const", 32'(bus.r_max), 32'hFF);

    // Hysteresis with k=0
    bus.window_log2 = 4'd0;
    bus.thr_high    = 8'd100;
    bus.thr_low     = 8'd80;
    step("hy", 1, 8'd90, 0);  check("hy.90", 32'(bus.out_of_range), 0);
    step("hy", 1, 8'd101, 0); check("hy.101", 32'(bus.out_of_range), 1);
    step("hy", 1, 8'd90, 0);  check("hy.90b", 32'(bus.out_of_range), 1);
    step("hy", 1, 8'd79, 0);  check("hy.79", 32'(bus.out_of_range), 0);
    step("hy", 1, 8'd80, 0);  check("hy.80", 32'(bus.out_of_range), 0);

    // Clear colliding with a sample
    bus.window_log2 = 4'd2;
    step("clr", 1, 8'd50, 0);
    step("clr", 1, 8'd60, 0);
    step("clr", 1, 8'd70, 1);
    check("clr.fill", 32'(bus.fill_count), 0);
    step("clr", 1, 8'd1, 0);
    step("clr", 1, 8'd2, 0);
    step("clr", 1, 8'd3, 0);
    step("clr", 1, 8'd4, 0);
    check("clr.mean_const", 32'(bus.r_mean), 2);
    check("clr.max_const", 32'(bus.r_max), 4);

    // Mid-window reset after forcing OUTSIDE
    bus.window_log2 = 4'd0;
    step("pre", 1, 8'd200, 0);
    check("pre.oor", 32'(bus.out_of_range), 1);
    bus.window_log2 = 4'd2;
    step("mrst", 1, 8'd5, 0);
    step("mrst", 1, 8'd6, 0);
    reset = 1'b1;
    #1;
    model_reset();
    compare_all("mrst.async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step("mrst.post", 1, 8'd8, 0);
    check("mrst.mean_const", 32'(bus.r_mean), 8);

    // Randomized traffic with live config changes
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) bus.window_log2 = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 99) == 0) begin
        bus.thr_high = 8'($urandom_range(60, 255));
        bus.thr_low  = 8'($urandom_range(0, 200));
      end
      step("rnd", ($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 59) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ray_window_stats.md
RAY_WINDOW_STATS -- requirements
Module: ray_window_stats

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the width of the ray magnitude (unsigned, 1 integer bit + DATA_WIDTH-1 fraction bits).
REQ-002 SHALL have parameter MAX_LOG2, default 8, giving the largest window exponent; the largest window is 2^MAX_LOG2 samples.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  r is a valid sample this cycle, aligned with the ray magnitude after the upstream square-root latency.
REQ-006 r  in  DATA_WIDTH  unsigned ray magnitude from the upstream magnitude stage.
REQ-007 clear  in  1  synchronous discard of the partial window.
REQ-008 window_log2  in  4  window exponent k; window length N = 2^k.
REQ-009 thr_high  in  DATA_WIDTH  upper hysteresis threshold.
REQ-010 thr_low  in  DATA_WIDTH  lower hysteresis threshold.
REQ-011 out_valid  out  1  one-cycle pulse when a window completes.
REQ-012 r_mean  out  DATA_WIDTH  truncated mean of the last completed window.
REQ-013 r_max  out  DATA_WIDTH  maximum of the last completed window.
REQ-014 out_of_range  out  1  hysteresis state (1 = OUTSIDE).
REQ-015 fill_count  out  MAX_LOG2+1  samples accumulated in the current window.

Function
REQ-016 SHALL keep an accumulator DATA_WIDTH+MAX_LOG2 bits wide, which cannot overflow for any legal window.
REQ-017 SHALL latch k at each window start, i.e. after reset, after clear, or after a window completes; a mid-window change of window_log2 takes effect from the next window.
REQ-018 SHALL clamp a latched k greater than MAX_LOG2 to MAX_LOG2.
REQ-019 On in_valid, when the window is not yet complete, SHALL add r to the accumulator, update the running maximum, and increment fill_count.
REQ-020 On the in_valid that brings the sample count to N, SHALL on the next edge:
- set r_mean = (acc + r) >> k, with the fraction truncated;
- set r_max = max(running max, r);
- pulse out_valid high for one cycle;
- zero the accumulator, running maximum and fill_count.
No sample is dropped between windows.
REQ-021 Latency SHALL be 1 cycle from the completing in_valid to out_valid.
REQ-022 With k=0, every valid sample SHALL complete a window, so out_valid can be asserted on consecutive cycles.
REQ-023 r_mean and r_max SHALL hold their values between out_valid pulses.
REQ-024 clear SHALL zero the accumulator, running maximum and fill_count and SHALL NOT produce out_valid; if clear and in_valid are both high in a cycle, clear wins and that sample is discarded.
REQ-025 The hysteresis FSM SHALL have two states, INSIDE and OUTSIDE, and SHALL be evaluated only on a completed window's mean:
- INSIDE -> OUTSIDE when mean > thr_high;
- OUTSIDE -> INSIDE when mean < thr_low;
- otherwise it holds its state; equality never causes a transition.
REQ-026 out_of_range SHALL update in the same cycle that out_valid is asserted.
REQ-027 clear SHALL NOT alter the hysteresis state.

Reset
REQ-028 reset SHALL asynchronously force out_valid=0, r_mean=0, r_max=0, fill_count=0, the accumulator and running maximum to 0, FSM=INSIDE and out_of_range=0.
REQ-029 A reset asserted mid-window SHALL discard the partial window; the first window after release uses the window_log2 value sampled at that time.

Structure
REQ-030 Package calc_ray_pkg SHALL hold the DATA_WIDTH/MAX_LOG2 defaults and the INSIDE/OUTSIDE state encoding.
REQ-031 The hysteresis FSM SHALL be a sub-module named ray_hysteresis, with inputs clk, reset, update, value, thr_high, thr_low and output out_of_range.

Verification
REQ-032 k=2; samples 10,20,30,40 -> out_valid one cycle after sample 40, r_mean=25, r_max=40, fill_count=0.
REQ-033 k=0; samples 0x7F,0x01 on consecutive cycles -> two consecutive out_valid pulses, r_mean 0x7F then 0x01.
REQ-034 k=8; 256 samples of 0xFF -> r_mean=0xFF, r_max=0xFF, no overflow.
REQ-035 k=0; thr_high=100, thr_low=80; means 90,101,90,79,80 -> out_of_range 0,1,1,0,0.
REQ-036 k=2; clear on the same cycle as the 3rd sample, then samples 1,2,3,4 -> no out_valid from the first window; then r_mean=2, r_max=4.
REQ-037 k=2; reset asserted after 2 samples -> all outputs 0 immediately and FSM=INSIDE; after release, 4 samples of 8 -> r_mean=8.
